// File: rtl/clock_pkg.sv
// Shared state encodings, segment patterns, digit positions and BCD helpers
// for the multiplexed alarm clock.
package clock_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_RUN     = 3'd0;
    localparam state_t ST_SET_HR  = 3'd1;
    localparam state_t ST_SET_MIN = 3'd2;
    localparam state_t ST_SET_SEC = 3'd3;
    localparam state_t ST_ALM_HR  = 3'd4;
    localparam state_t ST_ALM_MIN = 3'd5;

    localparam logic [6:0] SEG_DASH  = 7'b100_0000;
    localparam logic [6:0] SEG_A     = 7'b111_0111;
    localparam logic [6:0] SEG_P     = 7'b111_0011;
    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    localparam logic [2:0] POS_H1     = 3'd7;
    localparam logic [2:0] POS_H0     = 3'd6;
    localparam logic [2:0] POS_SEP_HM = 3'd5;
    localparam logic [2:0] POS_M1     = 3'd4;
    localparam logic [2:0] POS_M0     = 3'd3;
    localparam logic [2:0] POS_SEP_MS = 3'd2;
    localparam logic [2:0] POS_S1     = 3'd1;
    localparam logic [2:0] POS_S0     = 3'd0;

    // Two-digit BCD increment that wraps to 00 after 'last'.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        logic [7:0] r;
        if (v == last)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
        return {3'b000, v[7:4]} * 7'd10 + {3'b000, v[3:0]};
    endfunction

endpackage

// File: rtl/clock_alarm_display_bcd_seg7.sv
// BCD digit to gfedcba segment decoder; non-decimal codes decode to blank.
module bcd_seg7
    import clock_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = 7'b011_1111;
            4'd1:    seg = 7'b000_0110;
            4'd2:    seg = 7'b101_1011;
            4'd3:    seg = 7'b100_1111;
            4'd4:    seg = 7'b110_0110;
            4'd5:    seg = 7'b110_1101;
            4'd6:    seg = 7'b111_1101;
            4'd7:    seg = 7'b000_0111;
            4'd8:    seg = 7'b111_1111;
            4'd9:    seg = 7'b110_1111;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/clock_alarm_display.sv
// hh:mm:ss clock with 12/24 h display, button set mode, alarm, hourly chime
// and an 8-position multiplexed 7-segment driver.
module clock_alarm_display
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned SCAN_DIV    = 6250,
    parameter int unsigned ALARM_SEC   = 30,
    parameter int unsigned CHIME_START = 55
) (
    input  logic       CP,
    input  logic       rst,
    input  logic       EN,
    input  logic       mode_12h,
    input  logic       btn_set,
    input  logic       btn_inc,
    input  logic       alarm_en,
    input  logic       alarm_clr,
    output logic [7:0] ledsel,
    output logic [6:0] led,
    output logic       ring,
    output logic       tick_1hz,
    output logic [2:0] set_state
);

    localparam int unsigned PW = $clog2(CLK_HZ);
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t        state;
    logic [PW-1:0] presc;
    logic [SW-1:0] scan_cnt;
    logic [2:0]    pos;
    logic [7:0]    hour, minute, second;
    logic [7:0]    al_hr, al_min;
    logic [7:0]    alarm_cnt;
    logic          alarm_active;

    logic          blink, running, advance, trigger;
    logic          show_alarm, pm, blank;
    logic [7:0]    t_hr, t_min, t_sec;
    logic [7:0]    disp_hr24, disp_hr, disp_min, disp_sec;
    logic [6:0]    hr_bin, hr12_bin, sec_bin, digit_seg;
    logic [3:0]    digit;

    assign tick_1hz  = EN && (presc == PW'(CLK_HZ - 1));
    assign blink     = presc < PW'(CLK_HZ / 2);
    assign running   = (state == ST_RUN) || (state == ST_ALM_HR) || (state == ST_ALM_MIN);
    assign advance   = tick_1hz && running;
    assign set_state = state;
    assign ledsel    = ~(8'd1 << pos);

    always_comb begin
        t_sec = bcd_inc(second, 8'h59);
        t_min = minute;
        t_hr  = hour;
        if (second == 8'h59) begin
            t_min = bcd_inc(minute, 8'h59);
            if (minute == 8'h59)
                t_hr = bcd_inc(hour, 8'h23);
        end
    end

    assign trigger = advance && alarm_en && (t_hr == al_hr) && (t_min == al_min) && (t_sec == 8'h00);

    always_ff @(posedge CP or posedge rst) begin
        if (rst) begin
            state  <= ST_RUN;
            hour   <= '0;
            minute <= '0;
            second <= '0;
            al_hr  <= '0;
            al_min <= '0;
        end else begin
            if (btn_set) begin
                state <= (state == ST_ALM_MIN) ? ST_RUN : state + 3'd1;
            end else if (btn_inc) begin
                case (state)
                    ST_SET_HR:  hour   <= bcd_inc(hour, 8'h23);
                    ST_SET_MIN: minute <= bcd_inc(minute, 8'h59);
                    ST_SET_SEC: second <= 8'h00;
                    ST_ALM_HR:  al_hr  <= bcd_inc(al_hr, 8'h23);
                    ST_ALM_MIN: al_min <= bcd_inc(al_min, 8'h59);
                    default: ;
                endcase
            end
            // advance only happens outside SET_*, so it never collides with a time edit
            if (advance) begin
                hour   <= t_hr;
                minute <= t_min;
                second <= t_sec;
            end
        end
    end

    always_ff @(posedge CP or posedge rst) begin
        if (rst)
            presc <= '0;
        else if ((state == ST_SET_SEC) && btn_inc && !btn_set)
            presc <= '0;
        else if (EN)
            presc <= tick_1hz ? '0 : presc + 1'b1;
    end

    // A clear or disarm outranks a trigger in the same cycle.
    always_ff @(posedge CP or posedge rst) begin
        if (rst) begin
            alarm_active <= 1'b0;
            alarm_cnt    <= '0;
        end else if (alarm_clr || !alarm_en) begin
            alarm_active <= 1'b0;
        end else if (trigger) begin
            alarm_active <= 1'b1;
            alarm_cnt    <= 8'(ALARM_SEC);
        end else if (alarm_active && tick_1hz) begin
            alarm_cnt <= alarm_cnt - 8'd1;
            if (alarm_cnt == 8'd1)
                alarm_active <= 1'b0;
        end
    end

    assign sec_bin = bcd_to_bin(second);

    always_ff @(posedge CP or posedge rst) begin
        if (rst)
            ring <= 1'b0;
        else
            ring <= alarm_active ? blink : ((minute == 8'h59) && (sec_bin >= 7'(CHIME_START)));
    end

    always_ff @(posedge CP or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            pos      <= POS_H1;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            pos      <= pos - 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign show_alarm = (state == ST_ALM_HR) || (state == ST_ALM_MIN);
    assign disp_hr24  = show_alarm ? al_hr  : hour;
    assign disp_min   = show_alarm ? al_min : minute;
    assign disp_sec   = show_alarm ? 8'h00  : second;
    assign pm         = disp_hr24 >= 8'h12;
    assign hr_bin     = bcd_to_bin(disp_hr24);

    always_comb begin
        if (hr_bin == 7'd0)
            hr12_bin = 7'd12;
        else if (hr_bin > 7'd12)
            hr12_bin = hr_bin - 7'd12;
        else
            hr12_bin = hr_bin;
        if (!mode_12h)
            disp_hr = disp_hr24;
        else if (hr12_bin >= 7'd10)
            disp_hr = {4'd1, 4'(hr12_bin - 7'd10)};
        else
            disp_hr = {4'd0, hr12_bin[3:0]};
    end

    always_comb begin
        case (pos)
            POS_H1:  digit = disp_hr[7:4];
            POS_H0:  digit = disp_hr[3:0];
            POS_M1:  digit = disp_min[7:4];
            POS_M0:  digit = disp_min[3:0];
            POS_S1:  digit = disp_sec[7:4];
            POS_S0:  digit = disp_sec[3:0];
            default: digit = 4'hF;
        endcase
    end

    bcd_seg7 u_seg (
        .bcd (digit),
        .seg (digit_seg)
    );

    always_comb begin
        case (pos)
            POS_H1, POS_H0: blank = (state == ST_SET_HR) || (state == ST_ALM_HR);
            POS_M1, POS_M0: blank = (state == ST_SET_MIN) || (state == ST_ALM_MIN);
            POS_S1, POS_S0: blank = (state == ST_SET_SEC);
            default:        blank = 1'b0;
        endcase
        if (pos == POS_SEP_HM)
            led = mode_12h ? (pm ? SEG_P : SEG_A) : SEG_DASH;
        else if (pos == POS_SEP_MS)
            led = SEG_DASH;
        else
            led = digit_seg;
        if (blank && !blink)
            led = SEG_BLANK;
    end

endmodule

// File: tb/tb_clock_alarm_display.sv
// Self-checking bench for clock_alarm_display: directed scenarios plus a random
// phase, all compared every cycle against a seconds-of-day reference model.
module tb_clock_alarm_display;

    localparam int CLK_HZ      = 16;
    localparam int SCAN_DIV    = 2;
    localparam int ALARM_SEC   = 30;
    localparam int CHIME_START = 55;

    localparam logic [6:0] S_DASH = 7'b100_0000;
    localparam logic [6:0] S_A    = 7'b111_0111;
    localparam logic [6:0] S_P    = 7'b111_0011;

    logic       CP = 1'b0;
    logic       rst, EN, mode_12h, btn_set, btn_inc, alarm_en, alarm_clr;
    logic [7:0] ledsel;
    logic [6:0] led;
    logic       ring, tick_1hz;
    logic [2:0] set_state;

    int checks = 0;
    int failures = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // reference model: time as seconds of day, alarm as hour/minute integers
    int m_t, m_ah, m_am, m_presc, m_state, m_aact, m_acnt, m_ring, m_scan, m_pos, m_ticks;
    int ticks_seen;
    logic [7:0] visited;

    clock_alarm_display #(
        .CLK_HZ      (CLK_HZ),
        .SCAN_DIV    (SCAN_DIV),
        .ALARM_SEC   (ALARM_SEC),
        .CHIME_START (CHIME_START)
    ) dut (
        .CP        (CP),
        .rst       (rst),
        .EN        (EN),
        .mode_12h  (mode_12h),
        .btn_set   (btn_set),
        .btn_inc   (btn_inc),
        .alarm_en  (alarm_en),
        .alarm_clr (alarm_clr),
        .ledsel    (ledsel),
        .led       (led),
        .ring      (ring),
        .tick_1hz  (tick_1hz),
        .set_state (set_state)
    );

    always #5 CP = ~CP;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_ah = 0; m_am = 0; m_presc = 0; m_state = 0;
        m_aact = 0; m_acnt = 0; m_ring = 0; m_scan = 0; m_pos = 7;
    endtask

    task automatic model_step();
        bit tick, run, trig, blink;
        int tn, h, m, s;
        tick  = EN && (m_presc == CLK_HZ - 1);
        blink = m_presc < CLK_HZ / 2;
        run   = (m_state == 0) || (m_state == 4) || (m_state == 5);
        m_ring = m_aact ? int'(blink) : int'((((m_t / 60) % 60) == 59) && ((m_t % 60) >= CHIME_START));
        tn = m_t;
        if (tick && run) tn = (m_t + 1) % 86400;
        trig = tick && run && alarm_en && (tn == m_ah * 3600 + m_am * 60);
        if (m_state == 3 && btn_inc && !btn_set) m_presc = 0;
        else if (EN) m_presc = (m_presc + 1) % CLK_HZ;
        if (alarm_clr || !alarm_en) m_aact = 0;
        else if (trig) begin m_aact = 1; m_acnt = ALARM_SEC; end
        else if (m_aact && tick) begin
            m_acnt--;
            if (m_acnt == 0) m_aact = 0;
        end
        h = tn / 3600; m = (tn / 60) % 60; s = tn % 60;
        if (btn_set) m_state = (m_state + 1) % 6;
        else if (btn_inc) begin
            case (m_state)
                1: h = (h + 1) % 24;
                2: m = (m + 1) % 60;
                3: s = 0;
                4: m_ah = (m_ah + 1) % 24;
                5: m_am = (m_am + 1) % 60;
                default: ;
            endcase
        end
        m_t = h * 3600 + m * 60 + s;
        if (tick) m_ticks++;
        if (m_scan == SCAN_DIV - 1) begin m_scan = 0; m_pos = (m_pos + 7) % 8; end
        else m_scan++;
    endtask

    function automatic logic [6:0] exp_led();
        int h, m, s, hd, fld, sel;
        bit alm;
        logic [6:0] v;
        alm = (m_state == 4) || (m_state == 5);
        h = alm ? m_ah : m_t / 3600;
        m = alm ? m_am : (m_t / 60) % 60;
        s = alm ? 0 : m_t % 60;
        hd = h;
        if (mode_12h) hd = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
        case (m_pos)
            7: v = seg_tab[hd / 10];
            6: v = seg_tab[hd % 10];
            5: v = mode_12h ? ((h >= 12) ? S_P : S_A) : S_DASH;
            4: v = seg_tab[m / 10];
            3: v = seg_tab[m % 10];
            2: v = S_DASH;
            1: v = seg_tab[s / 10];
            default: v = seg_tab[s % 10];
        endcase
        fld = (m_pos >= 6) ? 1 : ((m_pos == 4 || m_pos == 3) ? 2 : ((m_pos <= 1) ? 3 : 0));
        sel = (m_state == 1 || m_state == 4) ? 1 : ((m_state == 2 || m_state == 5) ? 2 : ((m_state == 3) ? 3 : 0));
        if (fld != 0 && fld == sel && m_presc >= CLK_HZ / 2) v = 7'd0;
        return v;
    endfunction

    task automatic cycle(input logic s, input logic i, input logic c);
        btn_set = s; btn_inc = i; alarm_clr = c;
        @(posedge CP);
        model_step();
        #1;
        chk("ledsel", ledsel, 8'hFF ^ (8'd1 << m_pos));
        chk("led", led, exp_led());
        chk("ring", ring, m_ring);
        chk("tick_1hz", tick_1hz, EN && (m_presc == CLK_HZ - 1));
        chk("set_state", set_state, m_state);
        if (tick_1hz === 1'b1) ticks_seen++;
        visited |= ~ledsel;
        btn_set = 0; btn_inc = 0; alarm_clr = 0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) cycle(0, 0, 0);
    endtask

    task automatic run_ticks(input int n);
        int target, budget;
        target = m_ticks + n;
        budget = (n + 1) * CLK_HZ * 4;
        while (m_ticks < target && budget > 0) begin cycle(0, 0, 0); budget--; end
        if (m_ticks < target) begin
            checks++; failures++;
            $error("FAIL run_ticks observed=timeout required=%0d ticks", n);
        end
    endtask

    // From RUN: walk all set states, landing on h:m:00 back in RUN.
    task automatic set_time(input int h, input int m);
        cycle(1, 0, 0); gap();
        repeat ((h - m_t / 3600 + 24) % 24) begin cycle(0, 1, 0); gap(); end
        cycle(1, 0, 0); gap();
        repeat ((m - (m_t / 60) % 60 + 60) % 60) begin cycle(0, 1, 0); gap(); end
        cycle(1, 0, 0); gap();
        cycle(0, 1, 0);
        cycle(1, 0, 0); cycle(1, 0, 0); cycle(1, 0, 0);
    endtask

    task automatic set_alarm(input int h, input int m);
        repeat (4) begin cycle(1, 0, 0); gap(); end
        repeat ((h - m_ah + 24) % 24) begin cycle(0, 1, 0); gap(); end
        cycle(1, 0, 0);
        repeat ((m - m_am + 60) % 60) begin cycle(0, 1, 0); gap(); end
        cycle(1, 0, 0);
    endtask

    task automatic check_display(input string tag, input int h1, input int h0, input logic [6:0] sep,
                                 input int m1, input int m0, input int s1, input int s0, input int n);
        int p;
        logic [6:0] e;
        for (int k = 0; k < n; k++) begin
            cycle(0, 0, 0);
            p = -1;
            for (int b = 0; b < 8; b++) if (ledsel === (8'hFF ^ (8'd1 << b))) p = b;
            chk({tag, "_onehot"}, p >= 0, 1);
            if (p >= 0) begin
                case (p)
                    7: e = seg_tab[h1];
                    6: e = seg_tab[h0];
                    5: e = sep;
                    4: e = seg_tab[m1];
                    3: e = seg_tab[m0];
                    2: e = S_DASH;
                    1: e = seg_tab[s1];
                    default: e = seg_tab[s0];
                endcase
                chk(tag, led, e);
            end
        end
    endtask

    initial begin
        int rh;
        rst = 1; EN = 0; mode_12h = 0; btn_set = 0; btn_inc = 0; alarm_en = 0; alarm_clr = 0;
        ticks_seen = 0; m_ticks = 0; visited = '0;
        model_reset();
        #3;
        chk("rst_ledsel", ledsel, 8'b0111_1111);
        chk("rst_led", led, 7'b011_1111);
        chk("rst_ring", ring, 0);
        chk("rst_tick", tick_1hz, 0);
        chk("rst_state", set_state, 0);
        @(posedge CP); #1; rst = 0;

        // one minute of free running
        EN = 1;
        repeat (60 * CLK_HZ) cycle(0, 0, 0);
        chk("tick_count", ticks_seen, 60);
        chk("positions_visited", visited, 8'hFF);
        check_display("t_00_01_00", 0, 0, S_DASH, 0, 1, 0, 0, 14);

        // midnight rollover, with an EN=0 hold first
        set_time(23, 59);
        run_ticks(59);
        EN = 0;
        check_display("hold_23_59_59", 2, 3, S_DASH, 5, 9, 5, 9, 100);
        EN = 1;
        run_ticks(1);
        check_display("t_00_00_00", 0, 0, S_DASH, 0, 0, 0, 0, 14);

        // 12-hour display
        set_time(13, 5);
        mode_12h = 1;
        run_ticks(1);
        check_display("pm_13_05", 0, 1, S_P, 0, 5, 0, 1, 14);
        set_time(0, 5);
        run_ticks(1);
        check_display("am_00_05", 1, 2, S_A, 0, 5, 0, 1, 14);
        mode_12h = 0;

        // alarm rings for ALARM_SEC seconds at half duty
        set_alarm(0, 2);
        alarm_en = 1;
        set_time(0, 1);
        run_ticks(59);
        rh = 0;
        repeat (33 * CLK_HZ) begin cycle(0, 0, 0); if (ring === 1'b1) rh++; end
        chk("alarm_ring_cycles", rh, ALARM_SEC * CLK_HZ / 2);

        // alarm silenced at tick 3
        set_time(0, 1);
        run_ticks(60);
        run_ticks(3);
        cycle(0, 0, 1);
        rh = 0;
        repeat (40) begin cycle(0, 0, 0); if (ring === 1'b1) rh++; end
        chk("alarm_clr_silent", rh, 0);

        // asynchronous reset while ringing
        set_time(0, 1);
        run_ticks(60);
        repeat (3) cycle(0, 0, 0);
        chk("ringing_before_reset", ring, 1);
        #2 rst = 1;
        #1;
        chk("async_rst_ring", ring, 0);
        chk("async_rst_ledsel", ledsel, 8'b0111_1111);
        chk("async_rst_led", led, 7'b011_1111);
        chk("async_rst_state", set_state, 0);
        @(posedge CP); #1; rst = 0;
        model_reset();
        alarm_en = 0;

        // SET_MIN wrap and set+inc collision
        set_time(1, 59);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        cycle(1, 1, 0);
        chk("set_inc_together_state", set_state, 3);
        cycle(0, 1, 0);
        cycle(1, 0, 0); cycle(1, 0, 0); cycle(1, 0, 0);
        run_ticks(1);
        check_display("min_wrap_01_00", 0, 1, S_DASH, 0, 0, 0, 1, 14);

        // hourly chime
        set_time(0, 59);
        run_ticks(54);
        cycle(0, 0, 0);
        chk("chime_54", ring, 0);
        run_ticks(1);
        cycle(0, 0, 0);
        chk("chime_55", ring, 1);
        run_ticks(4);
        cycle(0, 0, 0);
        chk("chime_59", ring, 1);
        run_ticks(1);
        cycle(0, 0, 0);
        chk("chime_off_01_00", ring, 0);

        // random mix of every input
        set_alarm(1, 1);
        for (int k = 0; k < 2000; k++) begin
            EN = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) mode_12h = ~mode_12h;
            if ($urandom_range(0, 99) == 0) alarm_en = ~alarm_en;
            cycle($urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 49) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
